// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: request/ready bus between the memory stage and data memory
interface mem_wb_stage_if #(parameter int DATA_W = 32);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage with MEM/WB register, stalls upstream during data-memory accesses
module mem_wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int WAIT_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    output logic              stall_out,
    mem_wb_stage_if.master    mem,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic              wb_mem_to_reg,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_reg_write,
    output logic              mem_timeout
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_nx;
    logic [7:0]        cnt;
    logic [DATA_W-1:0] lat_addr, lat_wdata;
    logic [REG_AW-1:0] lat_rd;
    logic              lat_rw, lat_ld, lat_we;
    logic              accept, done, tmo;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        accept   = state == IDLE && ex_valid && (ex_mem_read || ex_mem_write);
        done     = state == ACCESS && mem.mem_ready;
        tmo      = state == ACCESS && !mem.mem_ready && cnt == 8'(WAIT_LIMIT - 1);
        state_nx = accept ? ACCESS : (done || tmo) ? IDLE : state;
    end
    assign stall_out     = state == ACCESS;
    assign mem.mem_req   = state == ACCESS;
    assign mem.mem_we    = lat_we;
    assign mem.mem_addr  = lat_addr;
    assign mem.mem_wdata = lat_wdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            lat_rd        <= '0;
            lat_rw        <= 1'b0;
            lat_ld        <= 1'b0;
            lat_we        <= 1'b0;
            wb_valid      <= 1'b0;
            wb_alu_result <= '0;
            wb_mem_data   <= '0;
            wb_mem_to_reg <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            mem_timeout   <= 1'b0;
        end else begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            mem_timeout   <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (ex_valid && !accept) begin
                    wb_valid      <= 1'b1;
                    wb_alu_result <= ex_alu_result;
                    wb_rd         <= ex_rd;
                    wb_reg_write  <= ex_reg_write && ex_rd != '0;
                end
                if (accept) begin
                    lat_addr  <= ex_alu_result;
                    lat_wdata <= ex_store_data;
                    lat_rd    <= ex_rd;
                    lat_rw    <= ex_reg_write;
                    lat_ld    <= ex_mem_read;
                    lat_we    <= ex_mem_write && !ex_mem_read;
                end
            end else if (done || tmo) begin
                // a timeout retires as a harmless no-write slot
                wb_valid      <= 1'b1;
                wb_alu_result <= lat_addr;
                wb_rd         <= lat_rd;
                wb_mem_to_reg <= done && lat_ld;
                wb_reg_write  <= done && lat_ld && lat_rw && lat_rd != '0;
                mem_timeout   <= tmo;
                if (done && lat_ld) wb_mem_data <= mem.mem_rdata;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and randomized checks of mem_wb_stage against a transaction-level model
module tb_mem_wb_stage;
    localparam int WL = 4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_store_data = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic        stall_out, wb_valid, wb_mem_to_reg, wb_reg_write, mem_timeout;
    logic [31:0] wb_alu_result, wb_mem_data;
    logic [4:0]  wb_rd;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_alu = '0, exp_md = '0;
    logic [4:0]  exp_rd = '0;
    bit          alu_known = 1'b1, md_known = 1'b1;
    always #5 clk = ~clk;
    mem_wb_stage_if #(.DATA_W(32)) mem ();
    mem_wb_stage #(.DATA_W(32), .REG_AW(5), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .stall_out(stall_out),
        .mem(mem), .wb_valid(wb_valid), .wb_alu_result(wb_alu_result),
        .wb_mem_data(wb_mem_data), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .mem_timeout(mem_timeout)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_wb(input logic v, input logic rw, input logic m2r, input logic to);
        chk("wb_valid", 32'(wb_valid), 32'(v));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(rw));
        chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(m2r));
        chk("mem_timeout", 32'(mem_timeout), 32'(to));
        if (alu_known) begin
            chk("wb_alu_result", wb_alu_result, exp_alu);
            chk("wb_rd", 32'(wb_rd), 32'(exp_rd));
        end
        if (md_known) chk("wb_mem_data", wb_mem_data, exp_md);
    endtask
    task automatic garbage_ex();
        ex_alu_result = $urandom;
        ex_store_data = $urandom;
        ex_rd         = 5'($urandom);
        ex_reg_write  = 1'($urandom);
        ex_mem_read   = 1'($urandom);
        ex_mem_write  = 1'($urandom);
    endtask
    task automatic bubble();
        garbage_ex();
        ex_valid      = 1'b0;
        mem.mem_ready = 1'($urandom);
        mem.mem_rdata = $urandom;
        step();
        chk("bubble_stall", 32'(stall_out), 32'd0);
        chk("bubble_req", 32'(mem.mem_req), 32'd0);
        chk_wb(1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    // dly: ready rises in ACCESS cycle dly+1; dly >= WL means memory never answers
    task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw, input int dly,
                         input logic [31:0] rdata);
        bit memop;
        int n;
        memop = mr || mw;
        n = !memop ? 1 : (dly < WL ? dly + 2 : WL + 1);
        ex_valid = 1'b1; ex_alu_result = a; ex_store_data = sd; ex_rd = rd;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
        mem.mem_ready = 1'($urandom);
        mem.mem_rdata = $urandom;
        for (int k = 1; k <= n; k++) begin
            step();
            if (k < n) begin
                chk("acc_stall", 32'(stall_out), 32'd1);
                chk("acc_req", 32'(mem.mem_req), 32'd1);
                chk("acc_addr", mem.mem_addr, a);
                chk("acc_we", 32'(mem.mem_we), 32'(mw && !mr));
                chk("acc_wdata", mem.mem_wdata, sd);
                chk("acc_wb_valid", 32'(wb_valid), 32'd0);
                chk("acc_timeout", 32'(mem_timeout), 32'd0);
                garbage_ex();
                ex_valid = 1'($urandom);
                mem.mem_ready = (k == dly + 1);
                mem.mem_rdata = (k == dly + 1) ? rdata : $urandom;
            end
        end
        chk("ret_stall", 32'(stall_out), 32'd0);
        chk("ret_req", 32'(mem.mem_req), 32'd0);
        if (!memop) begin
            exp_alu = a; exp_rd = rd; alu_known = 1'b1;
            chk_wb(1'b1, rw && rd != 0, 1'b0, 1'b0);
        end else if (dly >= WL) begin
            alu_known = 1'b0; md_known = 1'b0;
            chk_wb(1'b1, 1'b0, 1'b0, 1'b1);
        end else begin
            exp_alu = a; exp_rd = rd; alu_known = 1'b1;
            if (mr) begin exp_md = rdata; md_known = 1'b1; end
            chk_wb(1'b1, mr && rw && rd != 0, mr, 1'b0);
        end
    endtask
    initial begin
        mem.mem_ready = 1'b0;
        mem.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_req", 32'(mem.mem_req), 32'd0);
        chk("rst_we", 32'(mem.mem_we), 32'd0);
        chk("rst_addr", mem.mem_addr, 32'd0);
        chk("rst_wdata", mem.mem_wdata, 32'd0);
        chk_wb(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h0000_00A5, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 0, 32'd0);
        bubble();
        issue(32'h0000_0100, 32'h5555_0000, 5'd7, 1'b1, 1'b1, 1'b0, 2, 32'hDEAD_BEEF);
        issue(32'h0000_0200, 32'h0000_1234, 5'd9, 1'b1, 1'b0, 1'b1, 0, 32'hFFFF_FFFF);
        issue(32'h0000_0300, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1, 32'hCAFE_F00D);
        issue(32'h0000_0042, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 0, 32'd0);
        bubble();
        issue(32'h0000_0400, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0, WL, 32'h1111_1111);
        issue(32'h0000_0077, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 0, 32'd0);
        issue(32'h0000_0500, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, WL - 1, 32'h2222_3333);
        issue(32'h0000_0088, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 0, 32'd0);
        issue(32'h0000_0600, 32'd0, 5'd0, 1'b1, 1'b1, 1'b0, 0, 32'h4444_5555);
        issue(32'h0000_0700, 32'h9999_9999, 5'd11, 1'b1, 1'b1, 1'b1, 0, 32'h6666_7777);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) bubble();
            else begin
                int op;
                op = $urandom_range(0, 4);
                issue($urandom, $urandom, 5'($urandom), 1'($urandom), op == 2 || op == 4,
                      op == 3 || op == 4, $urandom_range(0, WL + 1), $urandom);
            end
        end
        // reset in the second ACCESS cycle of a load
        ex_valid = 1'b1; ex_alu_result = 32'h0000_0800; ex_rd = 5'd12;
        ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        mem.mem_ready = 1'b0;
        step();
        step();
        chk("pre_rst_stall", 32'(stall_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(mem.mem_req), 32'd0);
        chk("arst_stall", 32'(stall_out), 32'd0);
        exp_alu = '0; exp_md = '0; exp_rd = '0; alu_known = 1'b1; md_known = 1'b1;
        chk_wb(1'b0, 1'b0, 1'b0, 1'b0);
        ex_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_stall", 32'(stall_out), 32'd0);
        chk("post_rst_req", 32'(mem.mem_req), 32'd0);
        chk_wb(1'b0, 1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register for the pipelined processor.
- Accepts one instruction per cycle from the EX/MEM register.
- Runs a request/ready handshake with data memory for loads and stores, and stalls upstream while an access is outstanding.
- Drives the write-back 2x1 mux: wb_alu_result to input X, wb_mem_data to input Y, wb_mem_to_reg to select s.

Parameters:
- DATA_W, 32: datapath and address width.
- REG_AW, 5: register-index width.
- WAIT_LIMIT, 15: maximum cycles in ACCESS without mem_ready before timeout abort (range 1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX/MEM slot holds a valid instruction.
- ex_alu_result  in  DATA_W  ALU result; doubles as memory address.
- ex_store_data  in  DATA_W  store data.
- ex_rd  in  REG_AW  destination register.
- ex_reg_write  in  1  instruction writes the register file.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- stall_out  out  1  hold EX/MEM and earlier stages.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ready.
- mem_ready  in  1  access complete.
- wb_valid  out  1  WB slot holds a retiring instruction.
- wb_alu_result  out  DATA_W  write-back mux input X.
- wb_mem_data  out  DATA_W  write-back mux input Y.
- wb_mem_to_reg  out  1  write-back mux select.
- wb_rd  out  REG_AW  destination register.
- wb_reg_write  out  1  register-file write enable.
- mem_timeout  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, wait counter=0, every output listed above = 0. This includes mem_req, which drops immediately even mid-access; the aborted instruction is lost.
- The FSM has two states, IDLE and ACCESS.
- stall_out = (state==ACCESS), combinational. While stalled, ex_* inputs are ignored and upstream must hold them stable.
- IDLE, ex_valid=0: next cycle is a bubble: wb_valid=0, wb_reg_write=0, wb_mem_to_reg=0. Data outputs hold their previous values.
- IDLE, ex_valid=1, no memory op: next cycle wb_valid=1, wb_alu_result=ex_alu_result, wb_rd=ex_rd, wb_mem_to_reg=0, wb_reg_write=ex_reg_write. This gives one-cycle latency.
- IDLE, ex_valid=1, with ex_mem_read or ex_mem_write: latch all ex_* fields and go to ACCESS.
  - Next cycle: mem_req=1, mem_addr=latched ex_alu_result, mem_wdata=latched store data, mem_we = (write and not read).
  - If both read and write are set, the read wins.
  - WB slot is a bubble while waiting.
- ACCESS: mem_req, mem_we, mem_addr and mem_wdata stay stable until completion. The wait counter increments each cycle mem_ready=0.
- ACCESS, mem_ready=1 sampled:
  - mem_req drops next cycle and state returns to IDLE.
  - WB update: wb_valid=1, wb_alu_result=latched address, wb_rd=latched rd.
  - Load: wb_mem_data=mem_rdata, wb_mem_to_reg=1, wb_reg_write=latched reg_write.
  - Store: wb_mem_to_reg=0, wb_reg_write=0, wb_mem_data unchanged.
  - stall_out is still 1 in the mem_ready cycle. The held upstream instruction is consumed in the following IDLE cycle.
- Minimum load/store occupancy is therefore 2 cycles: the accept cycle plus an ACCESS cycle with ready=1.
- Timeout: if the counter reaches WAIT_LIMIT with mem_ready=0:
  - state goes to IDLE, mem_req drops, mem_timeout pulses for one cycle.
  - wb_valid=1 with wb_reg_write=0 and wb_mem_to_reg=0, so no architectural write occurs.
  - The counter clears on every IDLE entry.
- mem_ready while in IDLE is ignored.
- wb_rd=0 forces wb_reg_write=0 in all cases.

Test Plan:
- Reset then ALU op: ex_valid=1, ex_alu_result=0x0000_00A5, ex_rd=3, ex_reg_write=1, no memory op. Required next cycle: wb_valid=1, wb_alu_result=0xA5, wb_rd=3, wb_reg_write=1, wb_mem_to_reg=0, stall_out=0 throughout.
- Load with 3-cycle memory delay: ex_mem_read=1, addr=0x100, rd=7, mem_ready high on the 3rd ACCESS cycle with rdata=0xDEAD_BEEF.
  - mem_req=1 and addr=0x100 stable for 3 cycles; stall_out=1 for 3 cycles.
  - Then wb_mem_data=0xDEADBEEF, wb_mem_to_reg=1, wb_reg_write=1, wb_rd=7.
- Store with ready=1 on the first ACCESS cycle: addr=0x200, data=0x1234. Required: mem_we=1, mem_wdata=0x1234 for one cycle, then wb_valid=1, wb_reg_write=0.
- Back-to-back load then ALU op held during the stall: the ALU op retires exactly one cycle after the load's WB cycle, with no loss or duplication.
- Timeout: WAIT_LIMIT=4, mem_ready held at 0. Required: mem_timeout pulses after 4 ACCESS cycles, wb_reg_write=0, and the next instruction proceeds normally.
- Reset asserted in the 2nd ACCESS cycle: mem_req and stall_out go to 0 immediately; after release, state is IDLE and all wb_* outputs are 0.
